fwd_ctrl: RTL



---
 rtl/cpu_pkg.sv | 25 ++
 rtl/fwd_match.sv | 26 ++
 rtl/fwd_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipeline's hazard/forwarding logic:
// register address width, operand-mux select encodings and the pipeline slot record.
package cpu_pkg;

  localparam int AW = 3;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;

  typedef struct packed {
    logic          valid;
    logic          wen;
    logic          load;
    logic [AW-1:0] rd;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, wen: 1'b0, load: 1'b0, rd: {AW{1'b0}}};

  // r0 is hardwired to zero, so a slot naming it never produces a forwardable value
  function automatic logic is_writer(input slot_t s, input logic [AW-1:0] r);
    return s.valid & s.wen & (s.rd == r) & (r != {AW{1'b0}});
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand forwarding priority encoder: the youngest in-flight writer of rs
// selects its pipeline register, otherwise the register file is used.
module fwd_match
  import cpu_pkg::*;
#(
  parameter int AW = cpu_pkg::AW
) (
  input  logic [AW-1:0] rs,
  input  slot_t         ex_slot,
  input  slot_t         mem_slot,
  output logic [1:0]    sel
);

  // EX result is younger than MEM result, so it takes priority
  always_comb begin
    sel = SEL_RF;
    if (is_writer(ex_slot, rs)) begin
      sel = SEL_EXM;
    end else if (is_writer(mem_slot, rs)) begin
      sel = SEL_MWB;
    end else begin
      sel = SEL_RF;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Operand-forwarding and load-use hazard controller: tracks EX/MEM/WB destinations,
// registers the ALU operand-mux selects and raises a one-cycle stall on load-use.
module fwd_ctrl
  import cpu_pkg::*;
#(
  parameter int AW = cpu_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic [AW-1:0] id_rd,
  input  logic          id_wen,
  input  logic          id_load,
  input  logic          flush,
  output logic [1:0]    sel_a,
  output logic [1:0]    sel_b,
  output logic          stall
);

  slot_t      ex_r;
  slot_t      mem_r;
  slot_t      wb_r;
  slot_t      ex_next_s;
  logic [1:0] sel_a_r;
  logic [1:0] sel_b_r;
  logic [1:0] match_a_s;
  logic [1:0] match_b_s;
  logic       load_use_s;
  logic       stall_s;

  fwd_match #(.AW(AW)) u_match_a (
    .rs       (id_rs1),
    .ex_slot  (ex_r),
    .mem_slot (mem_r),
    .sel      (match_a_s)
  );

  fwd_match #(.AW(AW)) u_match_b (
    .rs       (id_rs2),
    .ex_slot  (ex_r),
    .mem_slot (mem_r),
    .sel      (match_b_s)
  );

  // Load in EX cannot forward until it reaches MEM; flush overrides the stall
  always_comb begin
    load_use_s = ex_r.load & (is_writer(ex_r, id_rs1) | is_writer(ex_r, id_rs2));
    stall_s    = id_valid & ~flush & load_use_s;
  end

  // EX slot source: killed on flush, bubble on stall, otherwise the ID instruction
  always_comb begin
    ex_next_s = SLOT_EMPTY;
    if (flush || stall_s || !id_valid) begin
      ex_next_s = SLOT_EMPTY;
    end else begin
      ex_next_s = '{valid: 1'b1, wen: id_wen, load: id_load, rd: id_rd};
    end
  end

  // Pipeline slot advance and select registers share the ID->EX edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_r    <= SLOT_EMPTY;
      mem_r   <= SLOT_EMPTY;
      wb_r    <= SLOT_EMPTY;
      sel_a_r <= SEL_RF;
      sel_b_r <= SEL_RF;
    end else begin
      wb_r    <= mem_r;
      mem_r   <= ex_r;
      ex_r    <= ex_next_s;
      sel_a_r <= ex_next_s.valid ? match_a_s : SEL_RF;
      sel_b_r <= ex_next_s.valid ? match_b_s : SEL_RF;
    end
  end

  assign sel_a = sel_a_r;
  assign sel_b = sel_b_r;
  assign stall = stall_s;

endmodule
